// File: rtl/bucket_pkg.sv
// bucket_pkg: shared beat geometry and frame-tracking states
// for the token bucket producer/consumer slice
package bucket_pkg;

    localparam int DATA_BWIDTH = 5;
    localparam int BEAT_BYTES  = 1 << DATA_BWIDTH;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_FRM  = 2'd1,
        ST_DROP = 2'd2
    } state_e;

endpackage

// File: rtl/bucket_dec_skid.sv
// bucket_dec_skid: 2-entry output buffer toward the stream interface
// level_o is the occupancy left after this cycle's pop (used as read credit)
module bucket_dec_skid #(
    parameter int W = 256
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         push_i,
    input  logic [W-1:0] data_i,
    input  logic         eop_i,
    output logic         valid_o,
    output logic [W-1:0] data_o,
    output logic         eop_o,
    input  logic         ready_i,
    output logic [1:0]   level_o
);

    logic [1:0][W-1:0] data_q;
    logic [1:0]        eop_q;
    logic              wptr_q;
    logic              rptr_q;
    logic [1:0]        cnt_q;
    logic [1:0]        cnt_d;
    logic              pop;

    assign valid_o = (cnt_q != 2'd0);
    assign pop     = valid_o & ready_i;
    assign data_o  = data_q[rptr_q];
    assign eop_o   = eop_q[rptr_q];
    assign level_o = cnt_q - {1'b0, pop};
    assign cnt_d   = cnt_q + {1'b0, push_i} - {1'b0, pop};

    // Storage and pointers; a write and a pop may share a cycle
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            data_q <= '0;
            eop_q  <= '0;
            wptr_q <= 1'b0;
            rptr_q <= 1'b0;
            cnt_q  <= 2'd0;
        end else begin
            if (push_i) begin
                data_q[wptr_q] <= data_i;
                eop_q[wptr_q]  <= eop_i;
                wptr_q         <= ~wptr_q;
            end
            if (pop) begin
                rptr_q <= ~rptr_q;
            end
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/bucket_dec_rtn.sv
// bucket_dec_rtn: drains the rx FIFO, forwards beats, returns one token per beat
// Optional macro BUCKET_DEC_STAT_EN adds saturating frame/beat/error counters
module bucket_dec_rtn
    import bucket_pkg::*;
#(
    parameter int                     DATA_WIDTH    = BEAT_BYTES * 8,
    parameter int                     DEPTH_WIDTH   = 9,
    parameter logic [DEPTH_WIDTH-1:0] MAX_FRM_BEATS = 9'd62
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   rxff_empty,
    input  logic [DEPTH_WIDTH-1:0] rxff_waterline,
    output logic                   rxff_rd,
    input  logic [DATA_WIDTH-1:0]  rxff_rdata,
    input  logic                   rxff_reof,
    output logic                   tx_valid,
    output logic [DATA_WIDTH-1:0]  tx_data,
    output logic                   tx_eop,
    input  logic                   tx_ready,
    output logic [DEPTH_WIDTH-1:0] data_ff_waterline,
    output logic                   bucket_dec_wr,
    output logic [DEPTH_WIDTH-1:0] bucket_dec_data,
    output logic                   bucket_dec_wend,
`ifdef BUCKET_DEC_STAT_EN
    output logic [31:0]            stat_frm_cnt,
    output logic [31:0]            stat_beat_cnt,
    output logic [15:0]            stat_err_cnt,
`endif
    output logic                   frm_len_err
);

    localparam logic [DEPTH_WIDTH-1:0] ONE = DEPTH_WIDTH'(1);

    state_e                 state_q;
    logic [DEPTH_WIDTH-1:0] beat_cnt_q;
    logic [DEPTH_WIDTH-1:0] beat_idx;
    logic [DEPTH_WIDTH-1:0] dec_cnt_q;
    logic [DEPTH_WIDTH-1:0] dec_cnt_d;
    logic [DEPTH_WIDTH-1:0] wl_q;
    logic                   rd_d1_q;
    logic                   live;
    logic                   at_max;
    logic                   force_end;
    logic                   push;
    logic [1:0]             level;

    // beat_idx is the 1-based position of the beat now on rxff_rdata
    assign beat_idx  = beat_cnt_q + ONE;
    assign live      = (state_q != ST_DROP);
    assign at_max    = (beat_idx == MAX_FRM_BEATS);
    assign force_end = live & ~rxff_reof & at_max;
    assign push      = rd_d1_q & live;
    assign dec_cnt_d = dec_cnt_q + ONE;

    // Read only when the buffer can absorb every beat already requested
    assign rxff_rd = ~reset & ~rxff_empty
                   & ((level + {1'b0, rd_d1_q}) <= 2'd1);

    assign bucket_dec_wr     = rd_d1_q;
    assign bucket_dec_data   = dec_cnt_q;
    assign bucket_dec_wend   = push & (rxff_reof | force_end);
    assign frm_len_err       = rd_d1_q & force_end;
    assign data_ff_waterline = wl_q;

    bucket_dec_skid #(
        .W (DATA_WIDTH)
    ) u_skid (
        .clk     (clk),
        .reset   (reset),
        .push_i  (push),
        .data_i  (rxff_rdata),
        .eop_i   (rxff_reof | force_end),
        .valid_o (tx_valid),
        .data_o  (tx_data),
        .eop_o   (tx_eop),
        .ready_i (tx_ready),
        .level_o (level)
    );

    // Read pipeline, running token count and waterline copy
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_d1_q   <= 1'b0;
            dec_cnt_q <= '0;
            wl_q      <= '0;
        end else begin
            rd_d1_q <= rxff_rd;
            wl_q    <= rxff_waterline;
            if (rxff_rd) begin
                dec_cnt_q <= dec_cnt_d;
            end
        end
    end

    // Frame tracking: advances once per beat arriving from the FIFO
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            beat_cnt_q <= '0;
        end else if (rd_d1_q) begin
            unique case (state_q)
                ST_DROP: begin
                    if (rxff_reof) begin
                        state_q <= ST_IDLE;
                    end
                end
                default: begin
                    if (rxff_reof) begin
                        state_q    <= ST_IDLE;
                        beat_cnt_q <= '0;
                    end else if (at_max) begin
                        state_q    <= ST_DROP;
                        beat_cnt_q <= '0;
                    end else begin
                        state_q    <= ST_FRM;
                        beat_cnt_q <= beat_idx;
                    end
                end
            endcase
        end
    end

`ifdef BUCKET_DEC_STAT_EN
    logic [31:0] stat_frm_q;
    logic [31:0] stat_beat_q;
    logic [15:0] stat_err_q;

    // Saturating statistics
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stat_frm_q  <= '0;
            stat_beat_q <= '0;
            stat_err_q  <= '0;
        end else begin
            if (bucket_dec_wend && (stat_frm_q != '1)) begin
                stat_frm_q <= stat_frm_q + 32'd1;
            end
            if (rd_d1_q && (stat_beat_q != '1)) begin
                stat_beat_q <= stat_beat_q + 32'd1;
            end
            if (frm_len_err && (stat_err_q != '1)) begin
                stat_err_q <= stat_err_q + 16'd1;
            end
        end
    end

    assign stat_frm_cnt  = stat_frm_q;
    assign stat_beat_cnt = stat_beat_q;
    assign stat_err_cnt  = stat_err_q;
`endif

endmodule

// File: tb/tb_bucket_dec_rtn.sv
// tb_bucket_dec_rtn: directed scoreboard bench for bucket_dec_rtn
// FIFO model on the read side, monitors on token and stream outputs
module tb_bucket_dec_rtn;

    localparam int DW = 256;
    localparam int WW = 9;

    logic          clk = 1'b0;
    logic          reset;
    logic          rxff_empty;
    logic [WW-1:0] rxff_waterline;
    logic          rxff_rd;
    logic [DW-1:0] rxff_rdata;
    logic          rxff_reof;
    logic          tx_valid;
    logic [DW-1:0] tx_data;
    logic          tx_eop;
    logic          tx_ready;
    logic [WW-1:0] data_ff_waterline;
    logic          bucket_dec_wr;
    logic [WW-1:0] bucket_dec_data;
    logic          bucket_dec_wend;
    logic          frm_len_err;

    typedef struct {
        logic [DW-1:0] d;
        logic          reof;
    } beat_t;

    typedef struct {
        logic [WW-1:0] d;
        logic          w;
        logic          e;
    } tok_t;

    typedef struct {
        logic [DW-1:0] d;
        logic          eop;
    } tx_t;

    beat_t src_q[$];
    tok_t  tok_q[$];
    tx_t   tx_q[$];
    int    wr_cyc[$];

    int            vectors = 0;
    int            fails = 0;
    int            cyc = 0;
    int            tok_seen = 0;
    int            stall_rds = 0;
    bit            stall_win = 1'b0;
    bit            rd_seen = 1'b0;
    bit            hold_v = 1'b0;
    logic [DW-1:0] hold_d;
    logic          hold_e;

    bucket_dec_rtn dut (
        .clk               (clk),
        .reset             (reset),
        .rxff_empty        (rxff_empty),
        .rxff_waterline    (rxff_waterline),
        .rxff_rd           (rxff_rd),
        .rxff_rdata        (rxff_rdata),
        .rxff_reof         (rxff_reof),
        .tx_valid          (tx_valid),
        .tx_data           (tx_data),
        .tx_eop            (tx_eop),
        .tx_ready          (tx_ready),
        .data_ff_waterline (data_ff_waterline),
        .bucket_dec_wr     (bucket_dec_wr),
        .bucket_dec_data   (bucket_dec_data),
        .bucket_dec_wend   (bucket_dec_wend),
        .frm_len_err       (frm_len_err)
    );

    always #5 clk = ~clk;

    function automatic logic [DW-1:0] bw(input int t);
        logic [31:0] w;
        w = 32'hA500_0000 ^ 32'(t);
        return {8{w}};
    endfunction

    // FIFO model: 1-cycle read latency, flushed by reset
    always @(posedge clk) begin
        beat_t b;
        #1;
        if (reset) begin
            src_q.delete();
        end else if (rd_seen && src_q.size() > 0) begin
            b = src_q.pop_front();
            rxff_rdata = b.d;
            rxff_reof  = b.reof;
        end
        rxff_empty     = (src_q.size() == 0);
        rxff_waterline = WW'(src_q.size());
    end

    // Monitors: token return, stream beats, stream hold stability
    always @(negedge clk) begin
        tok_t et;
        tx_t  ex;
        cyc++;
        rd_seen = rxff_rd;
        if (stall_win && rxff_rd) stall_rds++;
        if (!reset) begin
            if (hold_v) begin
                vectors++;
                if (!tx_valid || tx_data !== hold_d || tx_eop !== hold_e) begin
                    fails++;
                    $display("FAIL tx_hold: valid=%0b eop=%0b data=%h, required valid=1 eop=%0b data=%h",
                             tx_valid, tx_eop, tx_data, hold_e, hold_d);
                end
            end
            hold_v = tx_valid && !tx_ready;
            hold_d = tx_data;
            hold_e = tx_eop;
            if (tx_valid && tx_ready) begin
                vectors++;
                if (tx_q.size() == 0) begin
                    fails++;
                    $display("FAIL tx_extra: got beat %h eop=%0b, required none", tx_data, tx_eop);
                end else begin
                    ex = tx_q.pop_front();
                    if (tx_data !== ex.d || tx_eop !== ex.eop) begin
                        fails++;
                        $display("FAIL tx_beat: got %h eop=%0b, required %h eop=%0b",
                                 tx_data, tx_eop, ex.d, ex.eop);
                    end
                end
            end
            if (bucket_dec_wr) begin
                vectors++;
                tok_seen++;
                wr_cyc.push_back(cyc);
                if (tok_q.size() == 0) begin
                    fails++;
                    $display("FAIL tok_extra: got data=%0d wend=%0b err=%0b, required none",
                             bucket_dec_data, bucket_dec_wend, frm_len_err);
                end else begin
                    et = tok_q.pop_front();
                    if (bucket_dec_data !== et.d || bucket_dec_wend !== et.w ||
                        frm_len_err !== et.e) begin
                        fails++;
                        $display("FAIL tok: got data=%0d wend=%0b err=%0b, required data=%0d wend=%0b err=%0b",
                                 bucket_dec_data, bucket_dec_wend, frm_len_err, et.d, et.w, et.e);
                    end
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic chk(input string n, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        vectors++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h, required %h", n, got, exp);
        end
    endtask

    task automatic push_beat(input int t, input bit r);
        src_q.push_back('{bw(t), r});
    endtask

    task automatic exp_tok(input int d, input bit w, input bit e);
        tok_q.push_back('{WW'(d), w, e});
    endtask

    task automatic exp_tx(input int t, input bit eop);
        tx_q.push_back('{bw(t), eop});
    endtask

    task automatic check_idle(input string n);
        chk({n, "_tx_valid"}, DW'(tx_valid), '0);
        chk({n, "_tx_eop"}, DW'(tx_eop), '0);
        chk({n, "_tx_data"}, tx_data, '0);
        chk({n, "_rxff_rd"}, DW'(rxff_rd), '0);
        chk({n, "_wr"}, DW'(bucket_dec_wr), '0);
        chk({n, "_data"}, DW'(bucket_dec_data), '0);
        chk({n, "_wend"}, DW'(bucket_dec_wend), '0);
        chk({n, "_err"}, DW'(frm_len_err), '0);
        chk({n, "_wl"}, DW'(data_ff_waterline), '0);
    endtask

    task automatic do_reset(input string n);
        reset = 1'b1;
        tok_q.delete();
        tx_q.delete();
        hold_v = 1'b0;
        @(negedge clk);
        check_idle(n);
        tick();
        tick();
        reset = 1'b0;
        tick();
    endtask

    task automatic wait_drain(input string n, input int budget);
        int k = 0;
        while ((tok_q.size() != 0 || tx_q.size() != 0) && k < budget) begin
            tick();
            k++;
        end
        vectors++;
        if (tok_q.size() != 0 || tx_q.size() != 0) begin
            fails++;
            $display("FAIL %s_drain: %0d tok %0d tx outstanding, required 0 0",
                     n, tok_q.size(), tx_q.size());
        end
        repeat (4) tick();
    endtask

    task automatic wait_toks(input string n, input int target, input int budget);
        int k = 0;
        while (tok_seen < target && k < budget) begin
            tick();
            k++;
        end
        vectors++;
        if (tok_seen < target) begin
            fails++;
            $display("FAIL %s_wait: got %0d tokens, required %0d", n, tok_seen, target);
        end
    endtask

    initial begin
        int base;
        reset          = 1'b1;
        tx_ready       = 1'b0;
        rxff_empty     = 1'b1;
        rxff_waterline = '0;
        rxff_rdata     = '0;
        rxff_reof      = 1'b0;
        @(negedge clk);
        check_idle("init");
        tick();
        reset = 1'b0;
        tick();

        // 3-beat frame
        tx_ready = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            push_beat(i, i == 3);
            exp_tok(i, i == 3, 1'b0);
            exp_tx(i, i == 3);
        end
        wait_drain("t1", 200);

        // 511 tokens in 61-beat frames, then a single-beat frame wraps to 0
        do_reset("r2");
        for (int i = 1; i <= 511; i++) begin
            push_beat(i, (i % 61 == 0) || (i == 511));
            exp_tok(i, (i % 61 == 0) || (i == 511), 1'b0);
            exp_tx(i, (i % 61 == 0) || (i == 511));
        end
        push_beat(512, 1'b1);
        exp_tok(0, 1'b1, 1'b0);
        exp_tx(512, 1'b1);
        push_beat(513, 1'b0);
        exp_tok(1, 1'b0, 1'b0);
        exp_tx(513, 1'b0);
        push_beat(514, 1'b1);
        exp_tok(2, 1'b1, 1'b0);
        exp_tx(514, 1'b1);
        wait_drain("t2", 3000);

        // 64-beat frame: truncated at 62, last two beats dropped
        do_reset("r3");
        for (int i = 1; i <= 64; i++) begin
            push_beat(i, i == 64);
            exp_tok(i, i == 62, i == 62);
            if (i <= 62) exp_tx(i, i == 62);
        end
        wait_drain("t3", 400);

        // Downstream stall mid-frame
        do_reset("r4");
        base = tok_seen;
        for (int i = 1; i <= 6; i++) begin
            push_beat(i, i == 6);
            exp_tok(i, i == 6, 1'b0);
            exp_tx(i, i == 6);
        end
        wait_toks("t4", base + 2, 100);
        tx_ready  = 1'b0;
        stall_rds = 0;
        stall_win = 1'b1;
        repeat (10) tick();
        stall_win = 1'b0;
        vectors++;
        if (stall_rds > 2) begin
            fails++;
            $display("FAIL t4_stall_rds: got %0d reads, required at most 2", stall_rds);
        end
        chk("t4_waterline", DW'(data_ff_waterline), DW'(rxff_waterline));
        tx_ready = 1'b1;
        wait_drain("t4", 200);

        // Back-to-back 2-beat frames at full rate
        do_reset("r5");
        base = wr_cyc.size();
        for (int i = 1; i <= 4; i++) begin
            push_beat(i, i % 2 == 0);
            exp_tok(i, i % 2 == 0, 1'b0);
            exp_tx(i, i % 2 == 0);
        end
        wait_drain("t5", 200);
        vectors++;
        if (wr_cyc.size() < base + 4 || wr_cyc[base + 3] - wr_cyc[base] != 3) begin
            fails++;
            $display("FAIL t5_gapless: got %0d tokens, span %0d, required 4 tokens span 3",
                     wr_cyc.size() - base,
                     (wr_cyc.size() >= base + 4) ? wr_cyc[base + 3] - wr_cyc[base] : -1);
        end

        // Reset in the middle of a 5-beat frame
        do_reset("r6");
        base = tok_seen;
        for (int i = 1; i <= 5; i++) begin
            push_beat(i, i == 5);
            exp_tok(i, i == 5, 1'b0);
            exp_tx(i, i == 5);
        end
        wait_toks("t6", base + 2, 100);
        do_reset("t6_rst");
        push_beat(101, 1'b0);
        exp_tok(1, 1'b0, 1'b0);
        exp_tx(101, 1'b0);
        push_beat(102, 1'b1);
        exp_tok(2, 1'b1, 1'b0);
        exp_tx(102, 1'b1);
        wait_drain("t6", 200);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
